// File: rtl/berger_one_pkg.sv
`default_nettype none
// ============================================================================
// Module      : berger_one_pkg
// Description : Shared constants, word field slices and FSM state encoding
//               for the Berger-coded word memory read path.
// Revision    : 1.0 - initial release
// ============================================================================
package berger_one_pkg;

    localparam int DATA_W  = 8;
    localparam int CHK_W   = 4;
    localparam int ADDR_W  = 4;
    localparam int WORD_W  = DATA_W + CHK_W;

    localparam int DATA_HI = WORD_W - 1;
    localparam int DATA_LO = CHK_W;
    localparam int CHK_HI  = CHK_W - 1;
    localparam int CHK_LO  = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RESP  = 3'd2,
        S_SCRUB = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/berger_one_check.sv
`default_nettype none
// ============================================================================
// Module      : berger_one_check
// Description : Combinational Berger codeword checker: recomputes the ones
//               count of the data field and compares it with the check field.
// Revision    : 1.0 - initial release
// ============================================================================
module berger_one_check #(
    parameter int DATA_W = 8,
    parameter int CHK_W  = 4
) (
    input  logic [DATA_W+CHK_W-1:0] word,
    output logic                    ok,
    output logic [CHK_W-1:0]        pop
);
    import berger_one_pkg::*;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pop = pop + {{(CHK_W-1){1'b0}}, word[CHK_W+i]};
        end
    end

    // Full-width compare: a check value above DATA_W can never match.
    assign ok = (word[CHK_W-1:0] == pop);

endmodule
`default_nettype wire

// File: rtl/berger_one_reader.sv
`default_nettype none
// ============================================================================
// Module      : berger_one_reader
// Description : Read-side controller for the 16-entry Berger-coded memory:
//               single-word reads with error flag plus a full-memory scrub.
// Revision    : 1.0 - initial release
// ============================================================================
module berger_one_reader #(
    parameter int DATA_W = 8,
    parameter int CHK_W  = 4,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W+CHK_W-1:0] mem_rdata,
    input  logic                    scrub_start,
    output logic                    scrub_busy,
    output logic                    scrub_done,
    output logic [ADDR_W:0]         err_count,
    output logic                    first_err_vld,
    output logic [ADDR_W-1:0]       first_err_addr
);
    import berger_one_pkg::*;

    state_t             r_state;
    logic               w_ok;
    logic [DATA_W-1:0]  w_data;

    berger_one_check #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_check (
        .word (mem_rdata),
        .ok   (w_ok),
        .pop  ()
    );

    assign w_data = mem_rdata[CHK_W +: DATA_W];

    // Held low while in reset so no request is taken before release.
    assign req_ready = rst && (r_state == S_IDLE) && !scrub_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            mem_addr       <= '0;
            scrub_busy     <= 1'b0;
            scrub_done     <= 1'b0;
            err_count      <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (scrub_start) begin
                        mem_addr       <= '0;
                        err_count      <= '0;
                        first_err_vld  <= 1'b0;
                        first_err_addr <= '0;
                        scrub_busy     <= 1'b1;
                        r_state        <= S_SCRUB;
                    end else if (req_valid) begin
                        mem_addr <= req_addr;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    rsp_data  <= w_data;
                    rsp_err   <= ~w_ok;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_SCRUB: begin
                    if (!w_ok) begin
                        err_count <= err_count + {{ADDR_W{1'b0}}, 1'b1};
                        if (!first_err_vld) begin
                            first_err_vld  <= 1'b1;
                            first_err_addr <= mem_addr;
                        end
                    end
                    mem_addr <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    // Last address checked: the wrap back to 0 is not rescanned.
                    if (mem_addr == {ADDR_W{1'b1}}) begin
                        scrub_busy <= 1'b0;
                        scrub_done <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    scrub_done <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
